div_ctrl: RTL and testbench

Sequencer between the control unit and the multi-cycle signed divider (`divUnit`). It accepts a divide request, latches the operands and issues the one-cycle `divOP` pulse. It then screens for divide-by-zero, waits out the fixed divider latency, and captures quotient and remainder into the architectural LO/HI registers in the one cycle they are valid. While it works it stalls the pipeline, and it can abort an in-flight divide on a pipeline flush.

---
 rtl/div_ctrl.sv | 172 +++++++++++++++++
 tb/tb_div_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_ctrl.sv
// div_ctrl: sequencer between the control unit and the multi-cycle signed
// divider. It latches a divide request, pulses div_op for one cycle, screens
// for divide-by-zero, waits out the fixed divider latency and captures
// quotient/remainder into LO/HI in the single cycle they are valid. A flush
// aborts the in-flight divide and resets the divider.
//
// Handshake: start is a level request sampled only in IDLE. There is no
// ready signal. busy is the stall indication, and it is high in every
// non-IDLE cycle. A start seen while busy is dropped, not queued.
//
// Ports
//   clk, reset             rising-edge clock, async active-low reset
//   start, flush           request / pipeline flush
//   op_a, op_b             dividend / divisor (signed, passed through untouched)
//   div_by_zero            divider's zero-divisor flag (valid in CHECK)
//   quotient, remainder    divider results (valid for one cycle)
//   div_op, div_rst        divider start pulse / divider sync reset
//   div_a, div_b           latched operands to the divider
//   hi, lo                 remainder / quotient architectural registers
//   busy, done, div_zero   stall, completion pulse, zero-divide exception
//   dbg_state              current FSM state, for observation only
module div_ctrl #(
  parameter int LATENCY = 36
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        flush,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        div_by_zero,
  input  logic [31:0] quotient,
  input  logic [31:0] remainder,
  output logic        div_op,
  output logic        div_rst,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    CHECK = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4,
    ABORT = 3'd5
  } state_t;

  localparam logic [5:0] LAT6 = 6'(LATENCY);

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] div_a_q, div_a_d;
  logic [31:0] div_b_q, div_b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        div_op_q, div_op_d;
  logic        div_rst_q, div_rst_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        div_zero_q, div_zero_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_a_d    = div_a_q;
    div_b_d    = div_b_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          div_a_d = op_a;
          div_b_d = op_b;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (flush) begin
          state_d = ABORT;
        end else begin
          // This edge is the divider's issue edge; cnt counts edges from here.
          cnt_d   = '0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (flush) begin
          state_d = ABORT;
        end else if (div_by_zero) begin
          // Going straight to DONE is the only way div_zero is raised.
          div_zero_d = 1'b1;
          state_d    = DONE;
        end else begin
          cnt_d   = cnt_q + 6'd1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (flush) begin
          state_d = ABORT;
        end else begin
          cnt_d = cnt_q + 6'd1;
          // Results are valid only in this cycle; the divider zeroes them next.
          if (cnt_q == LAT6) begin
            lo_d    = quotient;
            hi_d    = remainder;
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      ABORT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered copies decoded from the next state.
    div_op_d  = (state_d == ISSUE);
    div_rst_d = (state_d == ABORT);
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      div_a_q    <= '0;
      div_b_q    <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_op_q   <= 1'b0;
      // Held high through reset so a divide interrupted mid-flight is cleared.
      div_rst_q  <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_a_q    <= div_a_d;
      div_b_q    <= div_b_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_op_q   <= div_op_d;
      div_rst_q  <= div_rst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign div_op    = div_op_q;
  assign div_rst   = div_rst_q;
  assign div_a     = div_a_q;
  assign div_b     = div_b_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign div_zero  = div_zero_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Testbench for div_ctrl with a behavioural divider model and a scoreboard
// of expected {lo, hi, div_zero} checked on every done pulse.
module tb_div_ctrl;

  localparam int LAT = 36;

  logic        clk;
  logic        reset;
  logic        start;
  logic        flush;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        div_by_zero;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_op;
  logic        div_rst;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [2:0]  dbg_state;

  int n_pass  = 0;
  int n_total = 0;
  logic [64:0] exp_q[$];

  div_ctrl #(.LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .flush(flush),
    .op_a(op_a), .op_b(op_b), .div_by_zero(div_by_zero),
    .quotient(quotient), .remainder(remainder),
    .div_op(div_op), .div_rst(div_rst), .div_a(div_a), .div_b(div_b),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- divider model ----------------
  logic signed [31:0] m_a, m_b;
  int   m_cnt;
  logic m_busy;

  initial begin
    quotient = '0; remainder = '0; div_by_zero = 1'b0;
    m_busy = 1'b0; m_cnt = 0; m_a = '0; m_b = '0;
  end

  always @(posedge clk) begin
    quotient    <= '0;
    remainder   <= '0;
    div_by_zero <= 1'b0;
    if (div_rst) begin
      m_busy <= 1'b0;
    end else if (div_op) begin
      m_a         <= div_a;
      m_b         <= div_b;
      m_cnt       <= 0;
      m_busy      <= (div_b != 0);
      div_by_zero <= (div_b == 0);
    end else if (m_busy) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt + 1 == LAT) begin
        quotient  <= m_a / m_b;
        remainder <= m_a % m_b;
        m_busy    <= 1'b0;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [64:0] e;
    if (reset && done) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected_done: got lo=%0h hi=%0h dz=%0b, required no done", lo, hi, div_zero);
      end else begin
        e = exp_q.pop_front();
        if ({lo, hi, div_zero} !== e)
          $display("FAIL sb_result: got lo=%0h hi=%0h dz=%0b, required lo=%0h hi=%0h dz=%0b",
                   lo, hi, div_zero, e[64:33], e[32:1], e[0]);
        else n_pass++;
      end
    end
    if (reset && div_zero && !done) begin
      n_total++;
      $display("FAIL dz_without_done: got div_zero=1 done=0, required coincident");
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 ns after edge S (the edge that accepts start).
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op_a = a; op_b = b;
    step();
    start = 1'b0;
  endtask

  // Steps until done; n = edges since S, nb = busy cycles from the ISSUE cycle on.
  task automatic wait_done(output int n, output int nb, output int nop);
    n = -1; nb = busy ? 1 : 0; nop = 0;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (busy) nb++;
      if (div_op) nop++;
      if (done) begin n = i; break; end
    end
    if (n < 0) begin
      n_total++;
      $display("FAIL wait_done_timeout: got no done in 100 cycles, required done");
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0; start = 1'b0; flush = 1'b0; op_a = '0; op_b = '0;
    #12;
    n_total++;
    if ({busy, done, div_zero, div_op, div_rst} !== 5'b00001 || lo !== 0 || hi !== 0 || div_a !== 0 || div_b !== 0)
      $display("FAIL reset_outputs: got busy=%0b done=%0b dz=%0b op=%0b rst=%0b lo=%0h hi=%0h, required 0 0 0 0 1 0 0",
               busy, done, div_zero, div_op, div_rst, lo, hi);
    else n_pass++;
    #4 reset = 1'b1;
    step();
    n_total++;
    if (div_rst !== 1'b0) $display("FAIL reset_release_div_rst: got %0b, required 0", div_rst);
    else n_pass++;
  endtask

  task automatic test_basic();
    int n, nb, nop;
    exp_q.push_back({32'd14, 32'd2, 1'b0});
    issue(32'd100, 32'd7);
    n_total++;
    if (div_op !== 1'b1 || busy !== 1'b1) $display("FAIL basic_div_op: got op=%0b busy=%0b, required 1 1", div_op, busy);
    else n_pass++;
    n_total++;
    if (div_a !== 32'd100 || div_b !== 32'd7) $display("FAIL basic_latch: got %0d/%0d, required 100/7", div_a, div_b);
    else n_pass++;
    wait_done(n, nb, nop);
    n_total++;
    if (n !== 38 || nb !== 39 || nop !== 0)
      $display("FAIL basic_timing: got edges=%0d busy=%0d extra_op=%0d, required 38 39 0", n, nb, nop);
    else n_pass++;
    step();
    n_total++;
    if (busy !== 1'b0) $display("FAIL basic_idle: got busy=%0b, required 0", busy);
    else n_pass++;
  endtask

  task automatic test_negative();
    int n, nb, nop;
    exp_q.push_back({32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0});
    issue(-32'sd7, 32'd2);
    wait_done(n, nb, nop);
    n_total++;
    if (n !== 38) $display("FAIL neg_timing: got %0d, required 38", n);
    else n_pass++;
    step();
    n_total++;
    if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF)
      $display("FAIL neg_hold: got lo=%0h hi=%0h, required fffffffd ffffffff", lo, hi);
    else n_pass++;
  endtask

  task automatic test_zero();
    int n, nb, nop;
    exp_q.push_back({32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b1});
    issue(32'd5, 32'd0);
    wait_done(n, nb, nop);
    n_total++;
    if (n !== 2 || nb !== 3) $display("FAIL zero_timing: got edges=%0d busy=%0d, required 2 3", n, nb);
    else n_pass++;
    step();
    n_total++;
    if (busy !== 1'b0 || div_zero !== 1'b0) $display("FAIL zero_after: got busy=%0b dz=%0b, required 0 0", busy, div_zero);
    else n_pass++;
  endtask

  task automatic test_flush();
    int n, nb, nop;
    issue(32'd100, 32'd7);
    repeat (19) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    n_total++;
    if (div_rst !== 1'b1 || busy !== 1'b1 || done !== 1'b0)
      $display("FAIL flush_abort: got rst=%0b busy=%0b done=%0b, required 1 1 0", div_rst, busy, done);
    else n_pass++;
    step();
    n_total++;
    if (div_rst !== 1'b0 || busy !== 1'b0 || lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF)
      $display("FAIL flush_after: got rst=%0b busy=%0b lo=%0h hi=%0h, required 0 0 fffffffd ffffffff",
               div_rst, busy, lo, hi);
    else n_pass++;
    exp_q.push_back({32'd3, 32'd0, 1'b0});
    issue(32'd9, 32'd3);
    wait_done(n, nb, nop);
    n_total++;
    if (n !== 38) $display("FAIL flush_next_timing: got %0d, required 38", n);
    else n_pass++;
    step();
  endtask

  task automatic test_back_to_back();
    int n, nb, nop;
    exp_q.push_back({32'd14, 32'd2, 1'b0});
    exp_q.push_back({32'd10, 32'd0, 1'b0});
    start = 1'b1; op_a = 32'd100; op_b = 32'd7;
    step();
    op_a = 32'd50; op_b = 32'd5;
    wait_done(n, nb, nop);
    n_total++;
    if (n !== 38 || nop !== 0 || div_a !== 32'd100)
      $display("FAIL b2b_first: got edges=%0d extra_op=%0d div_a=%0d, required 38 0 100", n, nop, div_a);
    else n_pass++;
    step();
    n_total++;
    if (busy !== 1'b0) $display("FAIL b2b_idle_gap: got busy=%0b, required 0", busy);
    else n_pass++;
    step();
    start = 1'b0;
    n_total++;
    if (busy !== 1'b1 || div_op !== 1'b1 || div_a !== 32'd50 || div_b !== 32'd5)
      $display("FAIL b2b_accept: got busy=%0b op=%0b a=%0d b=%0d, required 1 1 50 5", busy, div_op, div_a, div_b);
    else n_pass++;
    wait_done(n, nb, nop);
    n_total++;
    if (n !== 38) $display("FAIL b2b_second_timing: got %0d, required 38", n);
    else n_pass++;
    step();
  endtask

  task automatic test_async_reset();
    int n, nb, nop;
    issue(32'd100, 32'd7);
    repeat (14) step();
    #3 reset = 1'b0;
    #1;
    n_total++;
    if ({busy, done, div_zero, div_op, div_rst} !== 5'b00001 || lo !== 0 || hi !== 0 || div_a !== 0 || div_b !== 0)
      $display("FAIL async_reset_outputs: got busy=%0b done=%0b dz=%0b op=%0b rst=%0b lo=%0h hi=%0h a=%0h, required 0 0 0 0 1 0 0 0",
               busy, done, div_zero, div_op, div_rst, lo, hi, div_a);
    else n_pass++;
    step();
    #3 reset = 1'b1;
    #1;
    n_total++;
    if (div_rst !== 1'b1) $display("FAIL async_reset_hold: got %0b, required 1", div_rst);
    else n_pass++;
    step();
    n_total++;
    if (div_rst !== 1'b0 || busy !== 1'b0) $display("FAIL async_reset_release: got rst=%0b busy=%0b, required 0 0", div_rst, busy);
    else n_pass++;
    exp_q.push_back({32'd14, 32'd2, 1'b0});
    issue(32'd100, 32'd7);
    wait_done(n, nb, nop);
    n_total++;
    if (n !== 38) $display("FAIL async_reset_rerun: got %0d, required 38", n);
    else n_pass++;
    step();
  endtask

  task automatic test_random();
    int n, nb, nop;
    logic signed [31:0] a, b;
    for (int k = 0; k < 3; k++) begin
      a = $signed($urandom_range(0, 2000)) - 1000;
      b = $signed($urandom_range(1, 40)) - 20;
      if (b == 0) b = 3;
      exp_q.push_back({a / b, a % b, 1'b0});
      issue(a, b);
      wait_done(n, nb, nop);
      n_total++;
      if (n !== 38) $display("FAIL random_timing: got %0d, required 38", n);
      else n_pass++;
      repeat ($urandom_range(1, 3)) step();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_zero();
    test_flush();
    test_back_to_back();
    test_async_reset();
    test_random();
    repeat (3) step();
    n_total++;
    if (exp_q.size() != 0) $display("FAIL sb_leftover: got %0d pending, required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
